// File: rtl/rv_timer.sv
// Memory-mapped timer/comparator with prescaler, one-shot/periodic modes and match interrupt.
// Optional PWM output and DUTY register are built only when RV_TIMER_PWM_EN is defined.
module rv_timer #(
    parameter int DIV_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic        rdy,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq,
    output logic        pwm
);

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_PRESC = 3'd1;
    localparam logic [2:0] A_CMP   = 3'd2;
    localparam logic [2:0] A_COUNT = 3'd3;
    localparam logic [2:0] A_STAT  = 3'd4;
    localparam logic [2:0] A_DUTY  = 3'd5;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    logic [2:0]       ctrl;      // {IE, PERIODIC, EN}
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] pcnt;
    logic [31:0]      cmp;
    logic [31:0]      count;
    logic             match;
    logic [31:0]      rmux;
    logic [31:0]      wm;
    logic [2:0]       sel;
    logic             wr, rd, tick, hit;
    logic             unused_adr;

    assign sel        = adr[4:2];
    assign unused_adr = ^adr[1:0];
    assign wr         = cs & rdy & (|we);
    assign rd         = cs & rdy & re;
    assign tick       = ctrl[0] && (pcnt == presc);
    assign hit        = tick && (count == cmp);
    assign irq        = match & ctrl[2];

`ifdef RV_TIMER_PWM_EN
    logic [31:0] duty;
    logic        pwm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            duty  <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (wr && sel == A_DUTY) duty <= wm;
            pwm_q <= ctrl[0] & (count < duty);
        end
    end

    assign pwm = pwm_q;
`else
    assign pwm = 1'b0;
`endif

    // Current value of the addressed register; feeds both the read port and byte-lane merge.
    always_comb begin
        rmux = '0;
        case (sel)
            A_CTRL:  rmux = {29'b0, ctrl};
            A_PRESC: rmux = 32'(presc);
            A_CMP:   rmux = cmp;
            A_COUNT: rmux = count;
            A_STAT:  rmux = {31'b0, match};
`ifdef RV_TIMER_PWM_EN
            A_DUTY:  rmux = duty;
`endif
            default: rmux = '0;
        endcase
    end

    assign wm = merge(rmux, dw, we);

    always_ff @(posedge clk) begin
        if (reset)                                    pcnt <= '0;
        else if (wr && (sel == A_PRESC || sel == A_CTRL)) pcnt <= '0;
        else if (!ctrl[0] || tick)                    pcnt <= '0;
        else                                          pcnt <= pcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)                        ctrl    <= '0;
        else if (wr && sel == A_CTRL)     ctrl    <= wm[2:0];
        else if (hit && !ctrl[1])         ctrl[0] <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            cmp   <= '0;
        end else if (wr) begin
            if (sel == A_PRESC) presc <= wm[DIV_W-1:0];
            if (sel == A_CMP)   cmp   <= wm;
        end
    end

    // Software write beats the tick; one-shot holds COUNT on the matching value.
    always_ff @(posedge clk) begin
        if (reset)                     count <= '0;
        else if (wr && sel == A_COUNT) count <= wm;
        else if (tick) begin
            if (hit) begin
                if (ctrl[1]) count <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // A new match outranks a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset)                                   match <= 1'b0;
        else if (hit)                                match <= 1'b1;
        else if (wr && sel == A_STAT && we[0] && dw[0]) match <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)   dr <= '0;
        else if (rd) dr <= rmux;
    end

endmodule

// File: tb/tb_rv_timer.sv
// Directed self-checking bench for rv_timer; read results flow through an expected-value queue.
module tb_rv_timer;
    localparam int DIV_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  adr;
    logic        cs, rdy, re;
    logic [3:0]  we;
    logic [31:0] dw, dr;
    logic        irq, pwm;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    rv_timer #(.DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .adr(adr), .cs(cs), .rdy(rdy), .we(we),
        .re(re), .dw(dw), .dr(dr), .irq(irq), .pwm(pwm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        adr = a; we = be; dw = d; cs = 1'b1; rdy = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 4'h0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
        exp_t x;
        sbq.push_back('{tag, e});
        adr = a; cs = 1'b1; rdy = 1'b1; re = 1'b1;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
        x = sbq.pop_front();
        check(x.tag, dr, x.exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] pmask;
        pmask = (DIV_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << DIV_W) - 32'd1);
        reset = 1'b1; adr = '0; cs = 0; rdy = 1; re = 0; we = '0; dw = '0;
        idle(2);
        reset = 1'b0;

        check("rst_dr", dr, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_pwm", {31'b0, pwm}, 32'h0);
        for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'h0, "rst_reg");

        // Periodic: PRESC=3, CMP=4 -> match every 20 clocks
        wr(5'h04, 4'hF, 32'd3);
        wr(5'h08, 4'hF, 32'd4);
        wr(5'h00, 4'hF, 32'h7);
        idle(19);
        check("per_irq_early", {31'b0, irq}, 32'h0);
        idle(1);
        check("per_irq_rise", {31'b0, irq}, 32'h1);
        rd(5'h0C, 32'h0, "per_count0");
        rd(5'h10, 32'h1, "per_stat");
        wr(5'h10, 4'h1, 32'h1);
        idle(16);
        check("per2_irq_early", {31'b0, irq}, 32'h0);
        idle(1);
        check("per2_irq_rise", {31'b0, irq}, 32'h1);

        // One-shot
        do_reset();
        wr(5'h04, 4'hF, 32'd0);
        wr(5'h08, 4'hF, 32'd2);
        wr(5'h00, 4'hF, 32'h5);
        idle(2);
        check("os_irq_early", {31'b0, irq}, 32'h0);
        idle(1);
        check("os_irq", {31'b0, irq}, 32'h1);
        rd(5'h00, 32'h4, "os_ctrl");
        rd(5'h0C, 32'h2, "os_count");
        idle(5);
        rd(5'h0C, 32'h2, "os_count_hold");

        // W1C colliding with a match set, then a clean clear
        do_reset();
        wr(5'h04, 4'hF, 32'd0);
        wr(5'h08, 4'hF, 32'd2);
        wr(5'h00, 4'hF, 32'h7);
        idle(2);
        wr(5'h10, 4'h1, 32'h1);
        check("w1c_collide", {31'b0, irq}, 32'h1);
        wr(5'h10, 4'h1, 32'h1);
        check("w1c_clear", {31'b0, irq}, 32'h0);

        // Wrap without match, then match at 10; COUNT write beats tick
        do_reset();
        wr(5'h0C, 4'hF, 32'hFFFF_FFFE);
        wr(5'h08, 4'hF, 32'd10);
        wr(5'h04, 4'hF, 32'd0);
        wr(5'h00, 4'hF, 32'h3);
        rd(5'h0C, 32'hFFFF_FFFE, "wrap_pre");
        rd(5'h0C, 32'hFFFF_FFFF, "wrap_ff");
        rd(5'h0C, 32'h0, "wrap_0");
        rd(5'h10, 32'h0, "wrap_nomatch");
        idle(9);
        rd(5'h10, 32'h1, "wrap_match10");
        check("wrap_irq_ie0", {31'b0, irq}, 32'h0);
        wr(5'h0C, 4'hF, 32'h100);
        rd(5'h0C, 32'h100, "cnt_wr_wins");

        // PRESC write restarts the prescaler
        do_reset();
        wr(5'h04, 4'hF, 32'd3);
        wr(5'h08, 4'hF, 32'hFF);
        wr(5'h00, 4'hF, 32'h3);
        idle(2);
        wr(5'h04, 4'hF, 32'd3);
        idle(3);
        rd(5'h0C, 32'h0, "presc_clr_a");
        rd(5'h0C, 32'h1, "presc_clr_b");

        // Byte lanes, hold, rdy gating, masks
        do_reset();
        wr(5'h0C, 4'hF, 32'h1122_3344);
        wr(5'h0C, 4'b0010, 32'h0000_AB00);
        rd(5'h0C, 32'h1122_AB44, "lane_b1");
        idle(2);
        check("dr_hold", dr, 32'h1122_AB44);
        adr = 5'h00; cs = 1; re = 1; rdy = 0;
        @(negedge clk);
        cs = 0; re = 0; rdy = 1;
        check("rdy0_read", dr, 32'h1122_AB44);
        adr = 5'h08; cs = 1; we = 4'hF; dw = 32'd55; rdy = 0;
        @(negedge clk);
        cs = 0; we = 4'h0; rdy = 1;
        rd(5'h08, 32'h0, "rdy0_write");
        wr(5'h00, 4'b1110, 32'hFFFF_FFFF);
        rd(5'h00, 32'h0, "ctrl_lane0_only");
        wr(5'h04, 4'hF, 32'hFFFF_FFFF);
        rd(5'h04, pmask, "presc_mask");
        wr(5'h1C, 4'hF, 32'hFFFF_FFFF);
        rd(5'h1C, 32'h0, "rsvd_1c");
        rd(5'h18, 32'h0, "rsvd_18");

        // Reset beats a simultaneous write
        adr = 5'h08; cs = 1; we = 4'hF; dw = 32'd5; reset = 1;
        @(negedge clk);
        cs = 0; we = 4'h0; reset = 0;
        rd(5'h08, 32'h0, "rst_over_wr");

`ifdef RV_TIMER_PWM_EN
        do_reset();
        wr(5'h04, 4'hF, 32'd0);
        wr(5'h08, 4'hF, 32'd9);
        wr(5'h14, 4'hF, 32'd3);
        wr(5'h00, 4'hF, 32'h3);
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            check("pwm_wave", {31'b0, pwm}, {31'b0, (((k - 1) % 10) < 3)});
        end
        do_reset();
        check("pwm_rst", {31'b0, pwm}, 32'h0);
        for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'h0, "pwm_rst_reg");
        check("pwm_rst_after", {31'b0, pwm}, 32'h0);
`else
        do_reset();
        wr(5'h14, 4'hF, 32'd3);
        rd(5'h14, 32'h0, "duty_absent");
        wr(5'h00, 4'hF, 32'h3);
        idle(4);
        check("pwm_const0", {31'b0, pwm}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
